enc_lookup_sched: RTL and testbench

Scheduler for hash-encoding feature lookups. It holds up to N_ROWS in-flight lookup rows, one per sample point. Each row carries a TABLE_COL-bit column mask. The block issues one column lookup per cycle to the table memory, arbitrating round-robin across rows. It tracks outstanding returns per row and reports a row as done once every masked column has been sent and every feature has returned. It sits between the encoding front-end (which allocates rows) and the hash-table memory (which accepts requests and returns feature counts).

---
 rtl/enc_lookup_sched_pkg.sv | 14 +
 rtl/enc_lookup_sched_if.sv | 40 ++++
 rtl/enc_lookup_sched_lsb_find.sv | 20 ++
 rtl/enc_lookup_sched.sv | 166 ++++++++++++++++
 tb/tb_enc_lookup_sched.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/enc_lookup_sched_pkg.sv
// enc_lookup_sched shared types
// slot life-cycle states and outstanding-counter width
package enc_sched_pkg;

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } slot_state_e;

    localparam int OUTST_W = 16;

endpackage

// File: rtl/enc_lookup_sched_if.sv
// enc_lookup_sched bus bundle
// front-end alloc, memory req/ret and done channels
interface enc_lookup_sched_if #(
    parameter int TABLE_COL  = 128,
    parameter int DATA_WIDTH = 32,
    parameter int N_ROWS     = 4,
    parameter int ROW_W      = $clog2(N_ROWS),
    parameter int COL_W      = $clog2(TABLE_COL)
);
    logic                  alloc_valid;
    logic [TABLE_COL-1:0]  alloc_mask;
    logic                  alloc_ready;
    logic [ROW_W-1:0]      alloc_id;
    logic                  req_valid;
    logic                  req_ready;
    logic [ROW_W-1:0]      req_row;
    logic [COL_W-1:0]      req_col;
    logic                  ret_valid;
    logic [ROW_W-1:0]      ret_row;
    logic [DATA_WIDTH-1:0] ret_num;
    logic                  done_valid;
    logic [ROW_W-1:0]      done_row;
    logic                  done_ready;
    logic                  busy;
    logic                  err;

    modport slave (
        input  alloc_valid, alloc_mask, req_ready,
        input  ret_valid, ret_row, ret_num, done_ready,
        output alloc_ready, alloc_id, req_valid, req_row, req_col,
        output done_valid, done_row, busy, err
    );

    modport master (
        output alloc_valid, alloc_mask, req_ready,
        output ret_valid, ret_row, ret_num, done_ready,
        input  alloc_ready, alloc_id, req_valid, req_row, req_col,
        input  done_valid, done_row, busy, err
    );
endinterface

// File: rtl/enc_lookup_sched_lsb_find.sv
// lowest-set-bit finder
// returns index of the lowest set bit and an any-set flag
module lsb_find #(
    parameter int W  = 8,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any
);
    // scan from the top so the lowest set bit is the last to win
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

    assign any = |vec;
endmodule

// File: rtl/enc_lookup_sched.sv
// hash-encoding lookup scheduler
// round-robin column issue over row slots with return tracking
module enc_lookup_sched
    import enc_sched_pkg::*;
#(
    parameter int TABLE_COL  = 128,
    parameter int DATA_WIDTH = 32,
    parameter int N_ROWS     = 4
) (
    input logic               clk,
    input logic               rst,
    enc_lookup_sched_if.slave bus
);
    localparam int ROW_W = $clog2(N_ROWS);
    localparam int COL_W = $clog2(TABLE_COL);
    localparam int CW    = DATA_WIDTH + OUTST_W;

    slot_state_e          st_q      [N_ROWS];
    logic [TABLE_COL-1:0] mask_q    [N_ROWS];
    logic [TABLE_COL-1:0] sent_q    [N_ROWS];
    logic [OUTST_W-1:0]   outst_q   [N_ROWS];
    logic [OUTST_W-1:0]   outst_nxt [N_ROWS];
    logic [TABLE_COL-1:0] pend      [N_ROWS];
    logic [COL_W-1:0]     col_idx   [N_ROWS];

    logic [N_ROWS-1:0] col_any, last_pend, elig;
    logic [N_ROWS-1:0] free_vec, done_vec;
    logic [ROW_W-1:0]  rr_q, hold_row_q, sel, cand;
    logic [ROW_W-1:0]  free_id, done_id;
    logic              hold_q, sel_ok, any_free, any_done;
    logic              err_q, err_set, inc, hit;
    logic              alloc_fire, issue_fire, done_fire;
    logic [OUTST_W:0]  sum;
    int                j;

    for (genvar g = 0; g < N_ROWS; g++) begin : g_slot
        assign pend[g]      = mask_q[g] & ~sent_q[g];
        assign last_pend[g] = ~|(pend[g] & (pend[g] - TABLE_COL'(1)));
        assign elig[g]      = (st_q[g] == ISSUE) && col_any[g];
        assign free_vec[g]  = (st_q[g] == FREE);
        assign done_vec[g]  = (st_q[g] == DONE);

        lsb_find #(.W(TABLE_COL)) u_col (
            .vec (pend[g]),
            .idx (col_idx[g]),
            .any (col_any[g])
        );
    end

    lsb_find #(.W(N_ROWS)) u_free (
        .vec (free_vec),
        .idx (free_id),
        .any (any_free)
    );

    lsb_find #(.W(N_ROWS)) u_done (
        .vec (done_vec),
        .idx (done_id),
        .any (any_done)
    );

    // round-robin pick from rr_q; a stalled request keeps its slot
    always_comb begin
        sel    = hold_row_q;
        sel_ok = hold_q;
        j      = 0;
        cand   = '0;
        if (!hold_q) begin
            for (int k = N_ROWS - 1; k >= 0; k--) begin
                j    = (int'(rr_q) + k) % N_ROWS;
                cand = ROW_W'(j);
                if (elig[cand]) begin
                    sel    = cand;
                    sel_ok = 1'b1;
                end
            end
        end
    end

    assign issue_fire = sel_ok && bus.req_ready;
    assign alloc_fire = bus.alloc_valid && any_free;
    assign done_fire  = any_done && bus.done_ready;

    // issue increment and return decrement folded into one update
    always_comb begin
        err_set = 1'b0;
        inc     = 1'b0;
        hit     = 1'b0;
        sum     = '0;
        for (int i = 0; i < N_ROWS; i++) begin
            inc = issue_fire && (sel == ROW_W'(i));
            hit = bus.ret_valid && (bus.ret_row == ROW_W'(i));
            sum = {1'b0, outst_q[i]} + (OUTST_W + 1)'(inc);
            outst_nxt[i] = sum[OUTST_W-1:0];
            if (hit) begin
                if (st_q[i] == FREE || st_q[i] == DONE) begin
                    err_set = 1'b1;
                end else if (CW'(bus.ret_num) > CW'(sum)) begin
                    outst_nxt[i] = '0;
                    err_set      = 1'b1;
                end else begin
                    outst_nxt[i] = OUTST_W'(sum -
                        {1'b0, bus.ret_num[OUTST_W-1:0]});
                end
            end
        end
    end

    // slot life-cycle, per-slot bookkeeping and scheduler pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ROWS; i++) begin
                st_q[i]    <= FREE;
                mask_q[i]  <= '0;
                sent_q[i]  <= '0;
                outst_q[i] <= '0;
            end
            rr_q       <= '0;
            hold_q     <= 1'b0;
            hold_row_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < N_ROWS; i++) begin
                unique case (st_q[i])
                    FREE: begin
                        if (alloc_fire && free_id == ROW_W'(i)) begin
                            mask_q[i]  <= bus.alloc_mask;
                            sent_q[i]  <= '0;
                            outst_q[i] <= '0;
                            st_q[i]    <= (bus.alloc_mask == '0) ? DONE : ISSUE;
                        end
                    end
                    ISSUE: begin
                        outst_q[i] <= outst_nxt[i];
                        if (issue_fire && sel == ROW_W'(i)) begin
                            sent_q[i][col_idx[i]] <= 1'b1;
                            if (last_pend[i]) st_q[i] <= WAIT;
                        end
                    end
                    WAIT: begin
                        outst_q[i] <= outst_nxt[i];
                        if (outst_nxt[i] == '0) st_q[i] <= DONE;
                    end
                    DONE: begin
                        if (done_fire && done_id == ROW_W'(i)) st_q[i] <= FREE;
                    end
                    default: ;
                endcase
            end
            if (issue_fire) rr_q <= ROW_W'((int'(sel) + 1) % N_ROWS);
            hold_q     <= sel_ok && !bus.req_ready;
            hold_row_q <= sel;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign bus.alloc_ready = any_free;
    assign bus.alloc_id    = free_id;
    assign bus.req_valid   = sel_ok;
    assign bus.req_row     = sel;
    assign bus.req_col     = col_idx[sel];
    assign bus.done_valid  = any_done;
    assign bus.done_row    = done_id;
    assign bus.busy        = ~&free_vec;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_enc_lookup_sched.sv
// enc_lookup_sched bench
// directed scenarios then random traffic against a scoreboard
module tb_enc_lookup_sched;
    localparam int TC = 128;
    localparam int DW = 32;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    enc_lookup_sched_if #(.TABLE_COL(TC), .DATA_WIDTH(DW), .N_ROWS(NR)) bus ();

    enc_lookup_sched #(.TABLE_COL(TC), .DATA_WIDTH(DW), .N_ROWS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    int exp_q  [NR][$];
    int m_out  [NR];
    int m_left [NR];
    bit active [NR];
    int n_alloc, n_done;
    bit prev_stall;
    int prev_row, prev_col;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alloc_valid = 1'b0;
        bus.alloc_mask  = '0;
        bus.req_ready   = 1'b0;
        bus.ret_valid   = 1'b0;
        bus.ret_row     = '0;
        bus.ret_num     = '0;
        bus.done_ready  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic ret(input int row, input int num);
        bus.ret_valid = 1'b1;
        bus.ret_row   = 2'(row);
        bus.ret_num   = 32'(num);
    endtask

    function automatic logic [TC-1:0] rand_mask();
        logic [TC-1:0] m;
        int nb;
        m = '0;
        if ($urandom_range(0, 7) != 0) begin
            nb = int'($urandom_range(1, 6));
            for (int b = 0; b < nb; b++) m[$urandom_range(0, TC - 1)] = 1'b1;
        end
        return m;
    endfunction

    task automatic monitor_step();
        int lf, r, c, d;
        lf = -1;
        for (int i = NR - 1; i >= 0; i--) if (!active[i]) lf = i;
        chk("alloc_ready", 64'(bus.alloc_ready), 64'(lf >= 0));
        if (bus.alloc_valid && bus.alloc_ready && lf >= 0) begin
            chk("alloc_id", 64'(bus.alloc_id), 64'(lf));
            active[lf] = 1'b1;
            m_out[lf]  = 0;
            m_left[lf] = 0;
            exp_q[lf].delete();
            for (int b = 0; b < TC; b++) begin
                if (bus.alloc_mask[b]) begin
                    exp_q[lf].push_back(b);
                    m_left[lf]++;
                end
            end
            n_alloc++;
        end
        if (bus.req_valid) begin
            r = int'(bus.req_row);
            if (prev_stall) begin
                chk("req_hold_row", 64'(bus.req_row), 64'(prev_row));
                chk("req_hold_col", 64'(bus.req_col), 64'(prev_col));
            end
            if (bus.req_ready) begin
                chk("req_pending", 64'(exp_q[r].size() != 0), 64'(1));
                if (exp_q[r].size() != 0) begin
                    c = exp_q[r].pop_front();
                    chk("req_col", 64'(bus.req_col), 64'(c));
                    m_out[r]++;
                    m_left[r]--;
                end
            end
        end else if (prev_stall) begin
            chk("req_hold_valid", 64'(bus.req_valid), 64'(1));
        end
        prev_stall = bus.req_valid && !bus.req_ready;
        prev_row   = int'(bus.req_row);
        prev_col   = int'(bus.req_col);
        if (bus.done_valid) begin
            d = int'(bus.done_row);
            chk("done_complete",
                64'(active[d] && m_left[d] == 0 && m_out[d] == 0), 64'(1));
            if (bus.done_ready) begin
                active[d] = 1'b0;
                n_done++;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) monitor_step();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int er [4];
        int ec [4];
        logic [TC-1:0] fm [4];
        int r, n, guard, left;
        er = '{0, 1, 0, 1};
        ec = '{0, 0, 1, 1};
        fm = '{TC'(1), TC'(1), TC'(0), TC'(1)};

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        chk("rst alloc_ready", 64'(bus.alloc_ready), 64'(1));
        chk("rst req_valid", 64'(bus.req_valid), 64'(0));
        chk("rst done_valid", 64'(bus.done_valid), 64'(0));
        chk("rst busy", 64'(bus.busy), 64'(0));
        chk("rst err", 64'(bus.err), 64'(0));

        // two columns, returned in two parts
        rst = 1'b0;
        bus.alloc_valid = 1'b1;
        bus.alloc_mask  = TC'(5);
        bus.req_ready   = 1'b1;
        chk("t1 alloc_id", 64'(bus.alloc_id), 64'(0));
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        chk("t1 req_valid", 64'(bus.req_valid), 64'(1));
        chk("t1 req_row", 64'(bus.req_row), 64'(0));
        chk("t1 req_col0", 64'(bus.req_col), 64'(0));
        @(negedge clk);
        chk("t1 req_col2", 64'(bus.req_col), 64'(2));
        @(negedge clk);
        chk("t1 req_idle", 64'(bus.req_valid), 64'(0));
        chk("t1 busy", 64'(bus.busy), 64'(1));
        ret(0, 1);
        @(negedge clk);
        chk("t1 not_done", 64'(bus.done_valid), 64'(0));
        ret(0, 1);
        @(negedge clk);
        bus.ret_valid = 1'b0;
        chk("t1 done_valid", 64'(bus.done_valid), 64'(1));
        chk("t1 done_row", 64'(bus.done_row), 64'(0));
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
        chk("t1 busy_off", 64'(bus.busy), 64'(0));
        chk("t1 err", 64'(bus.err), 64'(0));

        // two rows interleave round-robin
        do_reset();
        bus.alloc_valid = 1'b1;
        bus.alloc_mask  = TC'(3);
        chk("t2 id0", 64'(bus.alloc_id), 64'(0));
        @(negedge clk);
        chk("t2 id1", 64'(bus.alloc_id), 64'(1));
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        bus.req_ready   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t2 req_valid", 64'(bus.req_valid), 64'(1));
            chk("t2 req_row", 64'(bus.req_row), 64'(er[k]));
            chk("t2 req_col", 64'(bus.req_col), 64'(ec[k]));
            @(negedge clk);
        end
        chk("t2 req_idle", 64'(bus.req_valid), 64'(0));
        chk("t2 busy", 64'(bus.busy), 64'(1));
        chk("t2 no_done", 64'(bus.done_valid), 64'(0));

        // empty mask completes without requests
        do_reset();
        bus.alloc_valid = 1'b1;
        bus.alloc_mask  = '0;
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        chk("t3 done_valid", 64'(bus.done_valid), 64'(1));
        chk("t3 done_row", 64'(bus.done_row), 64'(0));
        chk("t3 req_valid", 64'(bus.req_valid), 64'(0));
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
        chk("t3 busy", 64'(bus.busy), 64'(0));

        // stall, then issue and return in the same cycle
        do_reset();
        bus.alloc_valid = 1'b1;
        bus.alloc_mask  = TC'(8'h30);
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t4 stall_valid", 64'(bus.req_valid), 64'(1));
            chk("t4 stall_row", 64'(bus.req_row), 64'(0));
            chk("t4 stall_col", 64'(bus.req_col), 64'(4));
            @(negedge clk);
        end
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
        chk("t4 one_issue", 64'(bus.req_col), 64'(5));
        @(negedge clk);
        chk("t4 still_col5", 64'(bus.req_col), 64'(5));
        bus.req_ready = 1'b1;
        ret(0, 1);
        @(negedge clk);
        bus.req_ready = 1'b0;
        bus.ret_valid = 1'b0;
        chk("t5 req_idle", 64'(bus.req_valid), 64'(0));
        chk("t5 outst_kept", 64'(bus.done_valid), 64'(0));
        ret(0, 1);
        @(negedge clk);
        bus.ret_valid = 1'b0;
        chk("t5 done", 64'(bus.done_valid), 64'(1));
        chk("t5 err_clear", 64'(bus.err), 64'(0));
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready  = 1'b0;
        bus.alloc_valid = 1'b1;
        bus.alloc_mask  = TC'(3);
        bus.req_ready   = 1'b1;
        chk("t5 realloc_id", 64'(bus.alloc_id), 64'(0));
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        @(negedge clk);
        ret(0, 3);
        @(negedge clk);
        bus.ret_valid = 1'b0;
        bus.req_ready = 1'b0;
        chk("t5 err_set", 64'(bus.err), 64'(1));
        chk("t5 wait", 64'(bus.req_valid), 64'(0));
        @(negedge clk);
        chk("t5 sat_done", 64'(bus.done_valid), 64'(1));
        chk("t5 err_sticky", 64'(bus.err), 64'(1));

        // fill every slot, free one, then reset mid-stream
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_mask  = fm[i];
            chk("t6 fill_ready", 64'(bus.alloc_ready), 64'(1));
            chk("t6 fill_id", 64'(bus.alloc_id), 64'(i));
            @(negedge clk);
        end
        bus.alloc_valid = 1'b0;
        chk("t6 full", 64'(bus.alloc_ready), 64'(0));
        chk("t6 done_valid", 64'(bus.done_valid), 64'(1));
        chk("t6 done_row", 64'(bus.done_row), 64'(2));
        bus.done_ready = 1'b1;
        @(negedge clk);
        bus.done_ready = 1'b0;
        chk("t6 freed_ready", 64'(bus.alloc_ready), 64'(1));
        chk("t6 freed_id", 64'(bus.alloc_id), 64'(2));
        bus.alloc_valid = 1'b1;
        bus.alloc_mask  = TC'(8'hf0);
        bus.req_ready   = 1'b1;
        @(negedge clk);
        bus.alloc_valid = 1'b0;
        @(negedge clk);
        ret(1, 7);
        @(negedge clk);
        bus.ret_valid = 1'b0;
        chk("t6 err_set", 64'(bus.err), 64'(1));
        chk("t6 busy", 64'(bus.busy), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("t6 rst alloc_ready", 64'(bus.alloc_ready), 64'(1));
        chk("t6 rst req_valid", 64'(bus.req_valid), 64'(0));
        chk("t6 rst done_valid", 64'(bus.done_valid), 64'(0));
        chk("t6 rst busy", 64'(bus.busy), 64'(0));
        chk("t6 rst err", 64'(bus.err), 64'(0));

        // random traffic against the scoreboard
        do_reset();
        for (int i = 0; i < NR; i++) begin
            m_out[i]  = 0;
            m_left[i] = 0;
            active[i] = 1'b0;
            exp_q[i].delete();
        end
        n_alloc    = 0;
        n_done     = 0;
        prev_stall = 1'b0;
        mon_en     = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            bus.alloc_valid = ($urandom_range(0, 2) == 0);
            bus.alloc_mask  = rand_mask();
            bus.req_ready   = ($urandom_range(0, 3) != 0);
            bus.done_ready  = 1'($urandom_range(0, 1));
            bus.ret_valid   = 1'b0;
            r = int'($urandom_range(0, NR - 1));
            if (m_out[r] > 0 && $urandom_range(0, 2) == 0) begin
                n = int'($urandom_range(1, m_out[r]));
                ret(r, n);
                m_out[r] -= n;
            end
            @(negedge clk);
        end

        bus.alloc_valid = 1'b0;
        bus.req_ready   = 1'b1;
        bus.done_ready  = 1'b1;
        guard = 0;
        while (bus.busy && guard < 3000) begin
            bus.ret_valid = 1'b0;
            for (int i = NR - 1; i >= 0; i--) begin
                if (m_out[i] > 0) r = i;
            end
            if (m_out[r] > 0) begin
                ret(r, m_out[r]);
                m_out[r] = 0;
            end
            @(negedge clk);
            guard++;
        end
        idle_inputs();
        chk("drain_idle", 64'(bus.busy), 64'(0));
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        left = 0;
        for (int i = 0; i < NR; i++) left += exp_q[i].size() + int'(active[i]);
        chk("rand leftover", 64'(left), 64'(0));
        chk("rand done_count", 64'(n_done), 64'(n_alloc));
        chk("rand err", 64'(bus.err), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
